// File: rtl/snitch_icache_l0_mshr.sv
// Private per-port L0 instruction cache with multiple outstanding refills.
// Fully associative, round-robin eviction, next-line prefetch and
// out-of-order refill responses matched by slot ID.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   flush_valid_i                      invalidate all lines
//   enable_prefetching_i               allow next-line prefetch
//   in_addr_i/in_valid_i               fetch request
//   in_data_o/in_ready_o/in_error_o    combinational hit response
//   out_req_addr_o/out_req_id_o        registered refill request
//   out_req_valid_o/out_req_ready_i    refill request handshake
//   out_rsp_data_i/out_rsp_error_i     refill response payload
//   out_rsp_id_i/out_rsp_valid_i       refill response slot and valid
//   out_rsp_ready_o                    always ready
//   evt_miss_o/evt_hit_o/evt_prefetch_o  one-cycle event pulses
module snitch_icache_l0_mshr #(
  parameter int unsigned LINE_COUNT      = 4,
  parameter int unsigned LINE_WIDTH      = 128,
  parameter int unsigned FETCH_AW        = 32,
  parameter int unsigned FETCH_DW        = 32,
  parameter int unsigned NUM_OUTSTANDING = 2,
  localparam int unsigned IDW = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_valid_i,
  input  logic                  enable_prefetching_i,
  input  logic [FETCH_AW-1:0]   in_addr_i,
  input  logic                  in_valid_i,
  output logic [FETCH_DW-1:0]   in_data_o,
  output logic                  in_ready_o,
  output logic                  in_error_o,
  output logic [FETCH_AW-1:0]   out_req_addr_o,
  output logic [IDW-1:0]        out_req_id_o,
  output logic                  out_req_valid_o,
  input  logic                  out_req_ready_i,
  input  logic [LINE_WIDTH-1:0] out_rsp_data_i,
  input  logic                  out_rsp_error_i,
  input  logic [IDW-1:0]        out_rsp_id_i,
  input  logic                  out_rsp_valid_i,
  output logic                  out_rsp_ready_o,
  output logic                  evt_miss_o,
  output logic                  evt_hit_o,
  output logic                  evt_prefetch_o
);

  localparam int unsigned LINE_ALIGN  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned FETCH_ALIGN = $clog2(FETCH_DW / 8);
  localparam int unsigned TAG_W       = FETCH_AW - LINE_ALIGN;
  localparam int unsigned LIDX_W      = $clog2(LINE_COUNT);
  localparam int unsigned WORDS       = LINE_WIDTH / FETCH_DW;
  localparam int unsigned WIDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Line state
  logic [TAG_W-1:0]           r_tag  [LINE_COUNT];
  logic [LINE_WIDTH-1:0]      r_data [LINE_COUNT];
  logic [IDW-1:0]             r_slot [LINE_COUNT];
  logic [LINE_COUNT-1:0]      r_vld, r_pend, r_err, r_drop;
  logic [NUM_OUTSTANDING-1:0] r_busy;
  logic [LIDX_W-1:0]          r_rr;

  // Refill request register
  logic                r_req_valid;
  logic [FETCH_AW-1:0] r_req_addr;
  logic [IDW-1:0]      r_req_id;

  logic [TAG_W-1:0]  w_in_tag, w_next_tag, w_alloc_tag;
  logic              w_hit_any, w_hit, w_pend_match, w_next_present;
  logic [LIDX_W-1:0] w_hit_idx, w_rsp_idx, w_victim, w_cand;
  logic              w_rsp_hit, w_victim_ok, w_slot_ok;
  logic [IDW-1:0]    w_free_slot;
  logic [WIDX_W-1:0] w_word;
  logic              w_demand, w_can_alloc, w_alloc_demand, w_alloc_pf, w_alloc;
  logic              w_unused;

  assign w_in_tag   = in_addr_i[FETCH_AW-1:LINE_ALIGN];
  assign w_next_tag = w_in_tag + TAG_W'(1);
  assign w_unused   = ^in_addr_i;

  // Tag lookup: hit, pending match, next-line presence, response owner
  always_comb begin
    w_hit_any      = 1'b0;
    w_hit_idx      = '0;
    w_pend_match   = 1'b0;
    w_next_present = 1'b0;
    w_rsp_hit      = 1'b0;
    w_rsp_idx      = '0;
    for (int unsigned i = 0; i < LINE_COUNT; i++) begin
      if (r_vld[i] && (r_tag[i] == w_in_tag) && !w_hit_any) begin
        w_hit_any = 1'b1;
        w_hit_idx = LIDX_W'(i);
      end
      if (r_pend[i] && !r_drop[i] && (r_tag[i] == w_in_tag)) w_pend_match = 1'b1;
      if ((r_vld[i] || r_pend[i]) && (r_tag[i] == w_next_tag)) w_next_present = 1'b1;
      if (out_rsp_valid_i && r_pend[i] && (r_slot[i] == out_rsp_id_i) && !w_rsp_hit) begin
        w_rsp_hit = 1'b1;
        w_rsp_idx = LIDX_W'(i);
      end
    end
  end

  // Victim: first non-pending line from the round-robin pointer upward
  always_comb begin
    w_victim_ok = 1'b0;
    w_victim    = '0;
    w_cand      = '0;
    for (int unsigned i = 0; i < LINE_COUNT; i++) begin
      w_cand = r_rr + LIDX_W'(i);
      if (!w_victim_ok && !r_pend[w_cand]) begin
        w_victim_ok = 1'b1;
        w_victim    = w_cand;
      end
    end
  end

  // Lowest free refill slot; slots freed this cycle are not yet visible
  always_comb begin
    w_slot_ok   = 1'b0;
    w_free_slot = '0;
    for (int unsigned i = 0; i < NUM_OUTSTANDING; i++) begin
      if (!w_slot_ok && !r_busy[i]) begin
        w_slot_ok   = 1'b1;
        w_free_slot = IDW'(i);
      end
    end
  end

  // Allocation: demand miss wins over prefetch, nothing during flush
  assign w_hit          = in_valid_i & w_hit_any;
  assign w_demand       = in_valid_i & ~w_hit_any & ~w_pend_match;
  assign w_can_alloc    = ~flush_valid_i & w_slot_ok & w_victim_ok &
                          (~r_req_valid | out_req_ready_i);
  assign w_alloc_demand = w_demand & w_can_alloc;
  assign w_alloc_pf     = w_hit & enable_prefetching_i & ~w_next_present & w_can_alloc;
  assign w_alloc        = w_alloc_demand | w_alloc_pf;
  assign w_alloc_tag    = w_alloc_demand ? w_in_tag : w_next_tag;

  assign w_word    = (WORDS > 1) ? WIDX_W'(in_addr_i >> FETCH_ALIGN) : '0;
  assign in_data_o = FETCH_DW'(r_data[w_hit_idx] >> (32'(w_word) * FETCH_DW));
  assign in_ready_o      = w_hit;
  assign in_error_o      = w_hit & r_err[w_hit_idx];
  assign out_req_addr_o  = r_req_addr;
  assign out_req_id_o    = r_req_id;
  assign out_req_valid_o = r_req_valid;
  assign out_rsp_ready_o = 1'b1;
  assign evt_hit_o       = w_hit;
  assign evt_miss_o      = w_alloc_demand;
  assign evt_prefetch_o  = w_alloc_pf;

  // State update; response overrides flush for its own line, allocation last
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld       <= '0;
      r_pend      <= '0;
      r_err       <= '0;
      r_drop      <= '0;
      r_busy      <= '0;
      r_rr        <= '0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_id    <= '0;
      for (int unsigned i = 0; i < LINE_COUNT; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
        r_slot[i] <= '0;
      end
    end else begin
      if (flush_valid_i) begin
        r_vld  <= '0;
        r_drop <= r_drop | r_pend;
      end
      if (w_rsp_hit) begin
        r_data[w_rsp_idx] <= out_rsp_data_i;
        r_err[w_rsp_idx]  <= out_rsp_error_i;
        r_vld[w_rsp_idx]  <= ~r_drop[w_rsp_idx] & ~flush_valid_i;
        r_pend[w_rsp_idx] <= 1'b0;
        r_drop[w_rsp_idx] <= 1'b0;
        r_busy[r_slot[w_rsp_idx]] <= 1'b0;
      end
      if (w_alloc) begin
        r_tag[w_victim]     <= w_alloc_tag;
        r_vld[w_victim]     <= 1'b0;
        r_pend[w_victim]    <= 1'b1;
        r_err[w_victim]     <= 1'b0;
        r_drop[w_victim]    <= 1'b0;
        r_slot[w_victim]    <= w_free_slot;
        r_busy[w_free_slot] <= 1'b1;
        r_rr                <= w_victim + LIDX_W'(1);
        r_req_valid         <= 1'b1;
        r_req_addr          <= {w_alloc_tag, {LINE_ALIGN{1'b0}}};
        r_req_id            <= w_free_slot;
      end else if (out_req_ready_i) begin
        r_req_valid <= 1'b0;
      end
    end
  end

  // Every response must belong to an in-flight refill
  a_rsp_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_rsp_valid_i |-> w_rsp_hit);

endmodule

// File: tb/tb_snitch_icache_l0_mshr.sv
// Self-checking bench for snitch_icache_l0_mshr: refill requests are checked
// against a queue of expected {addr, id} entries, hits against a data model.
module tb_snitch_icache_l0_mshr;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         flush_valid_i, enable_prefetching_i;
  logic [31:0]  in_addr_i;
  logic         in_valid_i;
  logic [31:0]  in_data_o;
  logic         in_ready_o, in_error_o;
  logic [31:0]  out_req_addr_o;
  logic [0:0]   out_req_id_o;
  logic         out_req_valid_o, out_req_ready_i;
  logic [127:0] out_rsp_data_i;
  logic         out_rsp_error_i;
  logic [0:0]   out_rsp_id_i;
  logic         out_rsp_valid_i, out_rsp_ready_o;
  logic         evt_miss_o, evt_hit_o, evt_prefetch_o;

  snitch_icache_l0_mshr dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_valid_i(flush_valid_i),
    .enable_prefetching_i(enable_prefetching_i),
    .in_addr_i(in_addr_i), .in_valid_i(in_valid_i), .in_data_o(in_data_o),
    .in_ready_o(in_ready_o), .in_error_o(in_error_o),
    .out_req_addr_o(out_req_addr_o), .out_req_id_o(out_req_id_o),
    .out_req_valid_o(out_req_valid_o), .out_req_ready_i(out_req_ready_i),
    .out_rsp_data_i(out_rsp_data_i), .out_rsp_error_i(out_rsp_error_i),
    .out_rsp_id_i(out_rsp_id_i), .out_rsp_valid_i(out_rsp_valid_i),
    .out_rsp_ready_o(out_rsp_ready_o), .evt_miss_o(evt_miss_o),
    .evt_hit_o(evt_hit_o), .evt_prefetch_o(evt_prefetch_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic [0:0]  id;
  } req_t;

  req_t        exp_q[$];
  req_t        mon_e;
  logic [31:0] id_addr [2];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [127:0] line_data(input logic [31:0] a);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[k*32 +: 32] = word_of(a + 32'(4 * k));
    return d;
  endfunction

  // Request scoreboard: every handshake must match the oldest expectation
  always @(negedge clk_i) begin
    if (rst_ni && out_req_valid_o && out_req_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("req_unexpected", 64'({out_req_id_o, out_req_addr_o}), '1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("req_addr", 64'(out_req_addr_o), 64'(mon_e.addr));
        chk("req_id", 64'(out_req_id_o), 64'(mon_e.id));
        id_addr[out_req_id_o] = out_req_addr_o;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_req(input logic [31:0] a, input logic [0:0] id);
    exp_q.push_back({a, id});
  endtask

  task automatic set_rsp(input int id, input logic err);
    out_rsp_valid_i = 1'b1;
    out_rsp_id_i    = 1'(id);
    out_rsp_data_i  = line_data(id_addr[id]);
    out_rsp_error_i = err;
  endtask

  task automatic clr_rsp();
    out_rsp_valid_i = 1'b0;
    out_rsp_error_i = 1'b0;
  endtask

  task automatic send_rsp(input int id, input logic err);
    set_rsp(id, err);
    cyc();
    clr_rsp();
  endtask

  task automatic miss_step(input logic [31:0] a, input logic [0:0] id);
    in_valid_i = 1'b1;
    in_addr_i  = a;
    expect_req(a, id);
    @(negedge clk_i);
    chk("miss_evt", 64'(evt_miss_o), 64'd1);
    chk("miss_not_ready", 64'(in_ready_o), 64'd0);
    cyc();
    in_valid_i = 1'b0;
  endtask

  task automatic hit_check(input logic [31:0] a, input logic err);
    in_valid_i = 1'b1;
    in_addr_i  = a;
    @(negedge clk_i);
    chk("hit_ready", 64'(in_ready_o), 64'd1);
    chk("hit_data", 64'(in_data_o), 64'(word_of(a)));
    chk("hit_err", 64'(in_error_o), 64'(err));
    chk("hit_evt", 64'(evt_hit_o), 64'd1);
    chk("hit_no_pf", 64'(evt_prefetch_o), 64'd0);
    cyc();
    in_valid_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    flush_valid_i = 1'b0;
    enable_prefetching_i = 1'b0;
    in_addr_i = '0;
    in_valid_i = 1'b0;
    out_req_ready_i = 1'b1;
    out_rsp_data_i = '0;
    out_rsp_error_i = 1'b0;
    out_rsp_id_i = '0;
    out_rsp_valid_i = 1'b0;
    id_addr[0] = '0;
    id_addr[1] = '0;

    // Reset values
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", 64'(in_ready_o), 64'd0);
    chk("rst_error", 64'(in_error_o), 64'd0);
    chk("rst_req_valid", 64'(out_req_valid_o), 64'd0);
    chk("rst_evts", 64'({evt_miss_o, evt_hit_o, evt_prefetch_o}), 64'd0);
    chk("rst_rsp_ready", 64'(out_rsp_ready_o), 64'd1);
    cyc();
    rst_ni = 1'b1;
    cyc();

    // Basic miss, refill, then all words of the line hit
    miss_step(32'h100, 1'b0);
    in_valid_i = 1'b1;
    in_addr_i  = 32'h100;
    @(negedge clk_i);
    chk("req_valid_c1", 64'(out_req_valid_o), 64'd1);
    chk("pend_no_alloc", 64'(evt_miss_o), 64'd0);
    chk("pend_no_hit", 64'(in_ready_o), 64'd0);
    cyc();
    set_rsp(0, 1'b0);
    @(negedge clk_i);
    chk("rsp_cycle_not_ready", 64'(in_ready_o), 64'd0);
    cyc();
    clr_rsp();
    hit_check(32'h100, 1'b0);
    hit_check(32'h104, 1'b0);
    hit_check(32'h108, 1'b0);
    hit_check(32'h10C, 1'b0);

    // Prefetch with slot 0 busy gets slot 1; out-of-order responses
    miss_step(32'h700, 1'b0);
    enable_prefetching_i = 1'b1;
    expect_req(32'h110, 1'b1);
    in_valid_i = 1'b1;
    in_addr_i  = 32'h100;
    @(negedge clk_i);
    chk("pf_hit", 64'(in_ready_o), 64'd1);
    chk("pf_evt", 64'(evt_prefetch_o), 64'd1);
    chk("pf_no_miss", 64'(evt_miss_o), 64'd0);
    cyc();
    @(negedge clk_i);
    chk("pf_once", 64'(evt_prefetch_o), 64'd0);
    cyc();
    in_valid_i = 1'b0;
    enable_prefetching_i = 1'b0;
    send_rsp(1, 1'b0);
    send_rsp(0, 1'b0);
    hit_check(32'h110, 1'b0);
    hit_check(32'h118, 1'b0);
    hit_check(32'h700, 1'b0);
    hit_check(32'h70C, 1'b0);

    // Two outstanding misses, third stalls until a slot frees
    miss_step(32'h200, 1'b0);
    miss_step(32'h300, 1'b1);
    in_valid_i = 1'b1;
    in_addr_i  = 32'h400;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("stall_no_slot", 64'(evt_miss_o), 64'd0);
      cyc();
    end
    set_rsp(1, 1'b0);
    @(negedge clk_i);
    chk("freed_not_same_cycle", 64'(evt_miss_o), 64'd0);
    cyc();
    clr_rsp();
    expect_req(32'h400, 1'b1);
    @(negedge clk_i);
    chk("alloc_after_free", 64'(evt_miss_o), 64'd1);
    cyc();
    in_valid_i = 1'b0;
    send_rsp(0, 1'b0);
    hit_check(32'h200, 1'b0);
    hit_check(32'h304, 1'b0);
    send_rsp(1, 1'b0);
    hit_check(32'h40C, 1'b0);

    // Back-pressure: request held stable, full register blocks a new miss
    out_req_ready_i = 1'b0;
    miss_step(32'h500, 1'b0);
    in_valid_i = 1'b1;
    in_addr_i  = 32'h800;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("hold_valid", 64'(out_req_valid_o), 64'd1);
      chk("hold_addr", 64'(out_req_addr_o), 64'h500);
      chk("hold_id", 64'(out_req_id_o), 64'd0);
      chk("hold_no_alloc", 64'(evt_miss_o), 64'd0);
      cyc();
    end
    out_req_ready_i = 1'b1;
    expect_req(32'h800, 1'b1);
    @(negedge clk_i);
    chk("reload_same_cycle", 64'(evt_miss_o), 64'd1);
    cyc();
    in_valid_i = 1'b0;

    // Error refill is reported on hit
    send_rsp(0, 1'b1);
    hit_check(32'h500, 1'b1);
    hit_check(32'h508, 1'b1);
    send_rsp(1, 1'b0);
    hit_check(32'h804, 1'b0);

    // Flush with a refill in flight: line never validates, re-request
    miss_step(32'h600, 1'b0);
    flush_valid_i = 1'b1;
    in_valid_i = 1'b1;
    in_addr_i  = 32'h900;
    @(negedge clk_i);
    chk("flush_no_alloc", 64'(evt_miss_o), 64'd0);
    cyc();
    flush_valid_i = 1'b0;
    in_valid_i = 1'b0;
    send_rsp(0, 1'b0);
    expect_req(32'h600, 1'b0);
    in_valid_i = 1'b1;
    in_addr_i  = 32'h600;
    @(negedge clk_i);
    chk("flushed_not_ready", 64'(in_ready_o), 64'd0);
    chk("flushed_rerequest", 64'(evt_miss_o), 64'd1);
    cyc();
    in_valid_i = 1'b0;
    cyc();
    send_rsp(0, 1'b0);
    hit_check(32'h608, 1'b0);

    // Flush and response in the same cycle: not validated, slot freed
    miss_step(32'hA00, 1'b0);
    cyc();
    flush_valid_i = 1'b1;
    set_rsp(0, 1'b0);
    cyc();
    flush_valid_i = 1'b0;
    clr_rsp();
    expect_req(32'hA00, 1'b0);
    in_valid_i = 1'b1;
    in_addr_i  = 32'hA00;
    @(negedge clk_i);
    chk("flush_rsp_not_ready", 64'(in_ready_o), 64'd0);
    chk("flush_rsp_slot_free", 64'(evt_miss_o), 64'd1);
    cyc();
    in_valid_i = 1'b0;
    cyc();
    send_rsp(0, 1'b0);
    hit_check(32'hA04, 1'b0);

    repeat (3) cyc();
    chk("req_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
